prod_accum: RTL and testbench

- Downstream stage of the 3-bit array multiplier. Consumes its 6-bit product `p` one beat at a time over a valid/ready handshake.
- Accumulates N products into a frame sum, then presents the sum on an output valid/ready handshake.
- Provides the multiply-accumulate (dot-product) path built on the combinational multiplier. Wraps it with registered, back-pressured sequencing.

---
 rtl/prod_accum_pkg.sv | 22 ++
 rtl/prod_accum_sat_add.sv | 20 ++
 rtl/prod_accum.sv | 94 +++++++++
 tb/tb_prod_accum.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and width helpers for the product accumulator.
package prod_accum_pkg;

  localparam int PW_DEF = 6;
  localparam int AW_DEF = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Unsigned AW-bit add, clamped to all-ones on overflow; carry flags the clamp.
module sat_add #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] y,
  output logic          carry
);

  logic [AW:0] full;

  // One extra bit catches the wrap; clamp instead of wrapping.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[AW];
    y     = full[AW] ? {AW{1'b1}} : full[AW-1:0];
  end

endmodule

// File: rtl/prod_accum.sv
// Accumulates N multiplier products per frame and hands the saturated sum
// downstream over valid/ready. Input stalls while a sum is waiting.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int N  = 4,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic          busy
);

  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          carry;
  logic          accept;

  sat_add #(.AW(AW)) u_add (
    .a     (acc),
    .b     (AW'(in_p)),
    .y     (sum),
    .carry (carry)
  );

  // Ready only while accumulating; a held sum back-pressures the producer.
  assign in_ready = (state == ACC);
  assign accept   = in_valid & in_ready;
  assign busy     = (cnt != '0) | out_valid;

  // Frame FSM: accumulate N beats, then hold the sum until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      // Abort drops any partial frame, pending sum and same-cycle beat.
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (cnt == LAST) begin
              out_sum   <= sum;
              out_ovf   <= ovf | carry;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
              ovf <= ovf | carry;
            end
          end
        end
        HOLD: begin
          // Returning to ACC costs one cycle before the next beat lands.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench: three instances share stimulus (N=4/AW=8, N=4/AW=7,
// N=1/AW=8); each step checks the instance relevant to that scenario.
module tb_prod_accum;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [5:0] in_p;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [7:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [6:0] b_out_sum;
  logic       c_in_ready, c_out_valid, c_out_ovf, c_busy;
  logic [7:0] c_out_sum;

  int checks;
  int errors;

  prod_accum #(.PW(6), .N(4), .AW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_p(in_p), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf),
    .busy(a_busy)
  );

  prod_accum #(.PW(6), .N(4), .AW(7)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_p(in_p), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf),
    .busy(b_busy)
  );

  prod_accum #(.PW(6), .N(1), .AW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_p(in_p), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_sum(c_out_sum), .out_ovf(c_out_ovf),
    .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] p);
    in_valid = 1'b1;
    in_p     = p;
    step();
  endtask

  task automatic pulse_clr();
    in_valid = 1'b0;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_sum",   32'(a_out_sum),   0);
    chk("rst_out_ovf",   32'(a_out_ovf),   0);
    chk("rst_busy",      32'(a_busy),      0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready",  32'(a_in_ready),  1);

    // Frame 0,4,8,4 with immediate handoff
    beat(6'd0);
    beat(6'd4);
    chk("f1_mid_busy", 32'(a_busy), 1);
    beat(6'd8);
    chk("f1_no_early_valid", 32'(a_out_valid), 0);
    beat(6'd4);
    in_valid = 1'b0;
    chk("f1_out_valid", 32'(a_out_valid), 1);
    chk("f1_out_sum",   32'(a_out_sum),   16);
    chk("f1_out_ovf",   32'(a_out_ovf),   0);
    chk("f1_hold_ready", 32'(a_in_ready), 0);
    step();
    chk("f1_handoff_valid", 32'(a_out_valid), 0);
    chk("f1_bubble_ready",  32'(a_in_ready),  1);
    chk("f1_idle_busy",     32'(a_busy),      0);

    // Same stream, consumer stalls 5 cycles; held beat must not be taken
    pulse_clr();
    out_ready = 1'b0;
    beat(6'd0);
    beat(6'd4);
    beat(6'd8);
    beat(6'd4);
    in_p = 6'd9;
    for (int i = 0; i < 5; i++) begin
      chk("f2_stall_ready", 32'(a_in_ready), 0);
      chk("f2_stall_sum",   32'(a_out_sum),  16);
      chk("f2_stall_valid", 32'(a_out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    in_p      = 6'd1;
    step();
    chk("f2_handoff_valid", 32'(a_out_valid), 0);
    beat(6'd1);
    beat(6'd2);
    beat(6'd3);
    beat(6'd4);
    in_valid = 1'b0;
    chk("f2_next_sum", 32'(a_out_sum), 10);
    step();

    // Saturation: 4x49 fits in 8 bits, saturates in 7 bits
    pulse_clr();
    for (int i = 0; i < 4; i++) beat(6'd49);
    in_valid = 1'b0;
    chk("sat8_sum",  32'(a_out_sum), 196);
    chk("sat8_ovf",  32'(a_out_ovf), 0);
    chk("sat7_valid", 32'(b_out_valid), 1);
    chk("sat7_sum",  32'(b_out_sum), 127);
    chk("sat7_ovf",  32'(b_out_ovf), 1);
    step();
    for (int i = 0; i < 4; i++) beat(6'd1);
    in_valid = 1'b0;
    chk("sat7_next_sum", 32'(b_out_sum), 4);
    chk("sat7_next_ovf", 32'(b_out_ovf), 0);
    chk("sat8_next_sum", 32'(a_out_sum), 4);
    step();

    // clr mid-frame drops the partial sum and the same-cycle beat
    beat(6'd10);
    beat(6'd20);
    chk("clr_pre_busy", 32'(a_busy), 1);
    in_valid = 1'b1;
    in_p     = 6'd30;
    clr      = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy",  32'(a_busy),      0);
    chk("clr_valid", 32'(a_out_valid), 0);
    chk("clr_ready", 32'(a_in_ready),  1);
    beat(6'd1);
    beat(6'd2);
    beat(6'd3);
    beat(6'd4);
    in_valid = 1'b0;
    chk("clr_after_sum", 32'(a_out_sum), 10);
    step();

    // clr during HOLD discards the sum even with out_ready high
    for (int i = 0; i < 4; i++) beat(6'd2);
    in_valid = 1'b0;
    chk("clrh_valid_pre", 32'(a_out_valid), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clrh_valid", 32'(a_out_valid), 0);
    chk("clrh_ready", 32'(a_in_ready),  1);

    // Async reset between edges mid-frame
    beat(6'd5);
    beat(6'd5);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(a_busy),      0);
    chk("arst_valid", 32'(a_out_valid), 0);
    chk("arst_sum",   32'(a_out_sum),   0);
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) beat(6'd1);
    in_valid = 1'b0;
    chk("arst_after_sum",   32'(a_out_sum),   4);
    chk("arst_after_valid", 32'(a_out_valid), 1);
    step();

    // N=1: each accept goes straight to HOLD; back-to-back every 2 cycles
    pulse_clr();
    beat(6'd36);
    chk("n1_valid",  32'(c_out_valid), 1);
    chk("n1_sum",    32'(c_out_sum),   36);
    chk("n1_ready",  32'(c_in_ready),  0);
    in_p = 6'd20;
    step();
    chk("n1_bubble_valid", 32'(c_out_valid), 0);
    chk("n1_bubble_ready", 32'(c_in_ready),  1);
    step();
    chk("n1_second_valid", 32'(c_out_valid), 1);
    chk("n1_second_sum",   32'(c_out_sum),   20);
    in_valid = 1'b0;
    step();
    chk("n1_end_valid", 32'(c_out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
